// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a read and a write channel.
// Define MEM_PORT_ARBITER_STATS_EN to add saturating completion/timeout counters.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_rd_grant,
    output logic              o_rd_done,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_wr_grant,
    output logic              o_wr_done,
    output logic              o_timeout,
    output logic              o_busy,
`ifdef MEM_PORT_ARBITER_STATS_EN
    output logic [15:0]       o_rd_count,
    output logic [15:0]       o_wr_count,
    output logic [7:0]        o_to_count,
`endif
    output logic [2:0]        o_dbg_state
);

    // Handshake: i_*_req is a level held until the matching one-cycle o_*_done;
    // i_mem_ready is a one-cycle completion strobe honoured only in the access states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ACC  = 3'd1,
        ST_WR_ACC  = 3'd2,
        ST_RD_DONE = 3'd3,
        ST_WR_DONE = 3'd4
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_last_wr;
    logic [15:0]       r_to_cnt;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_grant;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_wr_grant;
    logic              r_wr_done;
    logic              r_timeout;

    logic w_pick_rd;
    logic w_pick_wr;
    logic w_to_hit;

    // On a tie the channel that was not served last wins.
    assign w_pick_rd = i_rd_req && (!i_wr_req || r_last_wr);
    assign w_pick_wr = i_wr_req && !w_pick_rd;
    assign w_to_hit  = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_last_wr   <= 1'b1;
            r_to_cnt    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_grant  <= 1'b0;
            r_rd_done   <= 1'b0;
            r_rd_data   <= '0;
            r_wr_grant  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_rd) begin
                        r_state    <= ST_RD_ACC;
                        r_mem_re   <= 1'b1;
                        r_rd_grant <= 1'b1;
                        r_mem_addr <= i_rd_addr;
                        r_last_wr  <= 1'b0;
                        r_to_cnt   <= '0;
                    end else if (w_pick_wr) begin
                        r_state     <= ST_WR_ACC;
                        r_mem_we    <= 1'b1;
                        r_wr_grant  <= 1'b1;
                        r_mem_addr  <= i_wr_addr;
                        r_mem_wdata <= i_wr_data;
                        r_last_wr   <= 1'b1;
                        r_to_cnt    <= '0;
                    end
                end
                ST_RD_ACC: begin
                    if (i_mem_ready) begin
                        r_state   <= ST_RD_DONE;
                        r_mem_re  <= 1'b0;
                        r_rd_done <= 1'b1;
                        r_rd_data <= i_mem_rdata;
                    end else if (w_to_hit) begin
                        r_state   <= ST_RD_DONE;
                        r_mem_re  <= 1'b0;
                        r_rd_done <= 1'b1;
                        r_rd_data <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                ST_WR_ACC: begin
                    if (i_mem_ready) begin
                        r_state   <= ST_WR_DONE;
                        r_mem_we  <= 1'b0;
                        r_wr_done <= 1'b1;
                    end else if (w_to_hit) begin
                        r_state   <= ST_WR_DONE;
                        r_mem_we  <= 1'b0;
                        r_wr_done <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                ST_RD_DONE, ST_WR_DONE: begin
                    // One-cycle bubble so the requester can drop its request.
                    r_state    <= ST_IDLE;
                    r_rd_done  <= 1'b0;
                    r_wr_done  <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_rd_grant <= 1'b0;
                    r_wr_grant <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_re    = r_mem_re;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rd_grant  = r_rd_grant;
    assign o_rd_done   = r_rd_done;
    assign o_rd_data   = r_rd_data;
    assign o_wr_grant  = r_wr_grant;
    assign o_wr_done   = r_wr_done;
    assign o_timeout   = r_timeout;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [7:0]  r_to_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
            r_to_count <= '0;
        end else begin
            if (r_rd_done && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
            if (r_wr_done && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
            if (r_timeout && (r_to_count != 8'hFF))    r_to_count <= r_to_count + 8'd1;
        end
    end

    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
    assign o_to_count = r_to_count;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder in driver tasks, completion scoreboard.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_rd_req;
    logic [31:0] i_rd_addr;
    logic        i_wr_req;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ready;
    logic        o_mem_re;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_rd_grant;
    logic        o_rd_done;
    logic [31:0] o_rd_data;
    logic        o_wr_grant;
    logic        o_wr_done;
    logic        o_timeout;
    logic        o_busy;
    logic [2:0]  o_dbg_state;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] o_rd_count;
    logic [15:0] o_wr_count;
    logic [7:0]  o_to_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;
    int exp_to   = 0;

    // Completion record: {is_write, timed_out, data}
    logic [33:0] exp_q[$];
    logic [33:0] m_got;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_rd_req(i_rd_req),
        .i_rd_addr(i_rd_addr),
        .i_wr_req(i_wr_req),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ready(i_mem_ready),
        .o_mem_re(o_mem_re),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_rd_grant(o_rd_grant),
        .o_rd_done(o_rd_done),
        .o_rd_data(o_rd_data),
        .o_wr_grant(o_wr_grant),
        .o_wr_done(o_wr_done),
        .o_timeout(o_timeout),
        .o_busy(o_busy),
`ifdef MEM_PORT_ARBITER_STATS_EN
        .o_rd_count(o_rd_count),
        .o_wr_count(o_wr_count),
        .o_to_count(o_to_count),
`endif
        .o_dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and port invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (n_rst) begin
            check("exclusive", {61'd0, o_mem_re & o_mem_we, o_rd_grant & o_wr_grant,
                                o_timeout & ~(o_rd_done | o_wr_done)}, 64'd0);
            if (o_rd_done || o_wr_done) begin
                check("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    m_got = exp_q.pop_front();
                    check("completion",
                          {30'd0, o_wr_done, o_timeout, (o_rd_done ? o_rd_data : o_mem_wdata)},
                          {30'd0, m_got});
                end
            end
        end
    end

    // Driver: one access on one channel, with a memory answering after lat cycles
    // of strobe (or never, when a timeout is expected). Called on a falling edge.
    task automatic do_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                             input int lat, input bit exp_tmo);
        int n;
        bit seen;
        if (is_wr) begin
            i_wr_req  = 1'b1;
            i_wr_addr = addr;
            i_wr_data = data;
            exp_wr++;
        end else begin
            i_rd_req  = 1'b1;
            i_rd_addr = addr;
            exp_rd++;
        end
        if (exp_tmo) exp_to++;
        exp_q.push_back({is_wr, exp_tmo, (exp_tmo && !is_wr) ? 32'd0 : data});
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            seen = is_wr ? o_mem_we : o_mem_re;
        end
        check("strobe_seen", 64'(seen), 64'd1);
        // Inputs change after grant; the port must keep the latched values.
        i_rd_addr = ~addr;
        i_wr_addr = ~addr;
        i_wr_data = data ^ 32'h0000_00FF;
        n = 0;
        while ((is_wr ? o_mem_we : o_mem_re) && n < 100) begin
            n++;
            check("acc_addr", 64'(o_mem_addr), 64'(addr));
            if (is_wr) check("acc_wdata", 64'(o_mem_wdata), 64'(data));
            check("acc_grant", {62'd0, o_rd_grant, o_wr_grant}, is_wr ? 64'd1 : 64'd2);
            i_mem_ready = !exp_tmo && (n == lat);
            i_mem_rdata = i_mem_ready ? data : $urandom;
            @(negedge clk);
        end
        i_mem_ready = 1'b0;
        check("acc_cycles", 64'(n), exp_tmo ? 64'(TO) : 64'(lat));
        check("done_flags", {61'd0, o_rd_done, o_wr_done, o_timeout}, {61'd0, !is_wr, is_wr, exp_tmo});
        i_rd_req = 1'b0;
        i_wr_req = 1'b0;
        @(negedge clk);
        check("idle_after", {59'd0, o_busy, o_rd_done, o_wr_done, o_rd_grant, o_wr_grant}, 64'd0);
        check("addr_hold", 64'(o_mem_addr), 64'(addr));
    endtask

    // Both requests held: expect RD first, then strict alternation, one done every 3 cycles.
    task automatic wait_alternating(input int k);
        int seen = 0;
        int last_cyc = 0;
        for (int c = 0; c < 40 && seen < k; c++) begin
            @(negedge clk);
            if (c == 0) check("first_grant", {62'd0, o_rd_grant, o_wr_grant}, 64'd2);
            if (o_rd_done || o_wr_done) begin
                check("alt_kind", 64'(o_wr_done), 64'(seen % 2));
                if (seen > 0) check("alt_spacing", 64'(c - last_cyc), 64'd3);
                last_cyc = c;
                seen++;
                if (seen == k) begin
                    i_rd_req    = 1'b0;
                    i_wr_req    = 1'b0;
                    i_mem_ready = 1'b0;
                end
            end
        end
        check("alt_count", 64'(seen), 64'(k));
    endtask

    initial begin
        n_rst       = 1'b0;
        i_rd_req    = 1'b1;
        i_wr_req    = 1'b1;
        i_rd_addr   = 32'h0000_1000;
        i_wr_addr   = 32'h0000_2000;
        i_wr_data   = 32'hA5A5_0001;
        i_mem_rdata = 32'h1234_5678;
        i_mem_ready = 1'b1;
        #1;
        check("reset_ctl", {53'd0, o_mem_re, o_mem_we, o_rd_grant, o_rd_done, o_wr_grant,
                            o_wr_done, o_timeout, o_busy, o_dbg_state}, 64'd0);
        check("reset_addr", 64'(o_mem_addr), 64'd0);
        check("reset_data", {o_mem_wdata, o_rd_data}, 64'd0);

        // Simultaneous requests held from reset, single-cycle memory.
        exp_q.push_back({2'b00, 32'h1234_5678});
        exp_q.push_back({2'b10, 32'hA5A5_0001});
        exp_q.push_back({2'b00, 32'h1234_5678});
        exp_q.push_back({2'b10, 32'hA5A5_0001});
        exp_rd += 2;
        exp_wr += 2;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        wait_alternating(4);
        @(negedge clk);

        do_access(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 2, 1'b0);
        do_access(1'b1, 32'h0000_0100, 32'h0000_0055, 3, 1'b0);
        do_access(1'b0, 32'h0000_0080, 32'hCAFE_F00D, 0, 1'b1);
        check("rd_data_cleared", 64'(o_rd_data), 64'd0);

        // Reset in the middle of a write access.
        i_wr_req  = 1'b1;
        i_wr_addr = 32'h0000_0200;
        i_wr_data = 32'h0000_0077;
        for (int w = 0; w < 10 && !o_mem_we; w++) @(negedge clk);
        check("abort_strobe_seen", 64'(o_mem_we), 64'd1);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("abort_ctl", {57'd0, o_mem_we, o_wr_grant, o_wr_done, o_busy, o_dbg_state}, 64'd0);
        check("abort_addr", 64'(o_mem_addr), 64'd0);
        exp_rd = 0;
        exp_wr = 0;
        exp_to = 0;
        i_rd_req    = 1'b1;
        i_rd_addr   = 32'h0000_0300;
        i_wr_addr   = 32'h0000_0400;
        i_wr_data   = 32'h3333_4444;
        i_mem_rdata = 32'h1111_2222;
        i_mem_ready = 1'b1;
        exp_q.push_back({2'b00, 32'h1111_2222});
        exp_q.push_back({2'b10, 32'h3333_4444});
        exp_rd++;
        exp_wr++;
        @(negedge clk);
        n_rst = 1'b1;
        wait_alternating(2);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_access(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h0FFF_FFFF), 4'h0},
                      $urandom, $urandom_range(1, TO - 1), 1'b0);
        end
        do_access(1'b1, 32'h0000_0500, 32'h0000_0099, 0, 1'b1);
        do_access(1'b0, 32'h0000_0600, 32'h0BAD_F00D, 0, 1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef MEM_PORT_ARBITER_STATS_EN
        check("rd_count", 64'(o_rd_count), 64'(exp_rd));
        check("wr_count", 64'(o_wr_count), 64'(exp_wr));
        check("to_count", 64'(o_to_count), 64'(exp_to));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
